if_fetch_queue: RTL
===================

// Module: if_fetch_queue
// PURPOSE
//  Parametrised instruction-fetch stage: owns the PC and issues sequential requests to
//  instruction memory over a req/gnt/rvalid handshake. Buffers returned {pc,inst}
//  pairs in a DEPTH-entry queue and presents them to decode over valid/ready.
//  A redirect (branch/jump from EX) flushes the queue and kills any in-flight response.
// PARAMETERS
//  XLEN      32            address/PC width
//  ILEN      32            instruction width
//  DEPTH     4             queue entries; power of 2, >=2
//  RESET_PC  32'h0000_0000 PC after reset
// PORTS
//  clk           in   1     clock, rising edge
//  rst           in   1     asynchronous, active-low reset
//  redirect      in   1     taken branch/jump; flush and restart fetch
//  redirect_pc   in   XLEN  new fetch PC; bits [1:0] forced to 0
//  imem_req      out  1     request valid
//  imem_addr     out  XLEN  request address (word aligned)
//  imem_gnt      in   1     request accepted this cycle
//  imem_rvalid   in   1     response valid; in order, >=1 cycle after gnt
//  imem_rdata    in   ILEN  response instruction
//  out_valid     out  1     queue head valid to decode
//  out_ready     in   1     decode accepts head (low = stall)
//  out_inst      out  ILEN  head instruction
//  out_pc        out  XLEN  head PC
//  out_npc       out  XLEN  head PC + 4
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, queue empty, no outstanding; imem_req=0, out_valid=0,
//    out_inst=0, out_pc=0, out_npc=0. Fetch resumes the first cycle after rst rises.
//  - Max one outstanding request. imem_req=1 when no outstanding and
//    (count + 0) < DEPTH and !redirect; imem_addr=fetch_pc. On req&&gnt:
//    outstanding=1, fetch_pc+=4 (wraps mod 2^XLEN).
//  - On imem_rvalid with outstanding && !kill: push {pc_of_req, imem_rdata}; outstanding=0.
//    Credit rule guarantees a slot; push into full queue is an assertion failure.
//  - Pop when out_valid && out_ready. Push and pop in the same cycle: count unchanged.
//  - Best-case latency: req -> gnt -> rvalid (+1) -> out_valid next cycle (registered head).
//  - Redirect (priority over everything): same-edge flush (count=0, out_valid=0 next
//    cycle), fetch_pc=redirect_pc&~3; if outstanding and rvalid not this cycle, set kill;
//    the next rvalid is dropped and clears kill/outstanding. No req while redirect=1.
//  - Redirect coincident with rvalid: data dropped, outstanding cleared, no kill.
//  - Redirect coincident with pop: pop discarded by flush.
//  - Pointers are log2(DEPTH)+1 bits; full/empty by MSB compare; wrap at DEPTH.
//  - Stall (out_ready=0) holds head stable; fetch continues until queue full.
//  - rst asserted mid-transaction: all state cleared; later rvalid without
//    outstanding is ignored.
// CONFIGURATION
//  IF_PERF_EN defined: adds outputs perf_fetched[31:0] (pushes accepted),
//    perf_flushes[31:0] (redirects), perf_stall[31:0] (cycles out_valid&&!out_ready);
//    saturating, cleared by rst.
//  Undefined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  - Package if_pkg: typedef fetch_entry_t {pc[XLEN], inst[ILEN]}; localparam
//    INST_BYTES=4; function pc_align().
//  - Sub-module if_queue: generic DEPTH-entry sync FIFO of fetch_entry_t with
//    push/pop/flush, full/empty/count. Top holds PC, handshake FSM
//    (IDLE, WAIT_RESP, WAIT_KILL) and redirect logic.
// TESTING
//  1. Reset, mem gnt=1, rvalid 1 cycle later, ready=1 -> out_pc 0,4,8,... consecutive;
//     out_npc=out_pc+4.
//  2. ready=0 for 20 cycles, DEPTH=4 -> exactly 4 pushes, imem_req low while full;
//     head stays pc=0; on ready=1 drain in order 0,4,8,C.
//  3. Redirect to 0x103 while request to 0x8 outstanding -> response for 0x8 dropped;
//     next out_pc=0x100.
//  4. Redirect same cycle as rvalid and pop -> queue empty next cycle, no kill,
//     next request addr=redirect_pc.
//  5. fetch_pc=0xFFFF_FFFC -> next imem_addr=0x0 (wrap).
//  6. rst low while outstanding, spurious rvalid after release -> ignored,
//     first out_pc=RESET_PC; with IF_PERF_EN counters read 0.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
// Holds the queue entry layout, the handshake FSM states and PC alignment.
package if_pkg;

    localparam int IF_XLEN    = 32;
    localparam int IF_ILEN    = 32;
    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [IF_ILEN-1:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RESP,
        ST_WAIT_KILL
    } fetch_state_t;

    function automatic logic [IF_XLEN-1:0] pc_align(input logic [IF_XLEN-1:0] pc);
        return pc & ~IF_XLEN'(INST_BYTES - 1);
    endfunction

endpackage

// File: rtl/if_queue.sv
// Generic DEPTH-entry synchronous FIFO with flush.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module if_queue
    import if_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  entry_t                 push_data_i,
    input  logic                   pop_i,
    output entry_t                 head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    entry_t      mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; the pointers decide validity and the top masks an empty head.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, redirect/kill, fetch queue.
// Define IF_PERF_EN to add saturating perf_fetched/perf_flushes/perf_stall counters.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int             XLEN     = IF_XLEN,
    parameter int             ILEN     = IF_ILEN,
    parameter int             DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_npc
`ifdef IF_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushes,
    output logic [31:0]     perf_stall
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } entry_t;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            fire, q_push, q_pop, q_full, q_empty;
    logic [CW-1:0]   q_count;
    entry_t          q_head, q_push_data;

    // Requests stop while in reset, while a response is owed, or while the queue has no slot.
    assign imem_req  = rst && (state_q == ST_IDLE) && (q_count < CW'(DEPTH)) && !redirect;
    assign imem_addr = fetch_pc_q;
    assign fire      = imem_req && imem_gnt;

    assign q_pop       = out_valid && out_ready;
    assign q_push_data = '{pc: req_pc_q, inst: imem_rdata};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        q_push     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    state_d    = ST_WAIT_RESP;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
                end
            end
            ST_WAIT_RESP: begin
                if (imem_rvalid) begin
                    state_d = ST_IDLE;
                    q_push  = !redirect;
                end else if (redirect) begin
                    state_d = ST_WAIT_KILL;
                end
            end
            ST_WAIT_KILL: begin
                if (imem_rvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (redirect) fetch_pc_d = XLEN'(pc_align(IF_XLEN'(redirect_pc)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    if_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk         (clk),
        .rst_ni      (rst),
        .flush_i     (redirect),
        .push_i      (q_push),
        .push_data_i (q_push_data),
        .pop_i       (q_pop),
        .head_o      (q_head),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .count_o     (q_count)
    );

    // The credit rule must never let a response land in a full queue.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst) !(q_push && q_full));

    assign out_valid = !q_empty;
    assign out_inst  = q_empty ? '0 : q_head.inst;
    assign out_pc    = q_empty ? '0 : q_head.pc;
    assign out_npc   = q_empty ? '0 : q_head.pc + XLEN'(INST_BYTES);

`ifdef IF_PERF_EN
    logic [31:0] perf_fetched_q, perf_flushes_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_flushes_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (q_push && (perf_fetched_q != '1))            perf_fetched_q <= perf_fetched_q + 32'd1;
            if (redirect && (perf_flushes_q != '1))          perf_flushes_q <= perf_flushes_q + 32'd1;
            if (out_valid && !out_ready && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushes = perf_flushes_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule
